// File: rtl/board_io_ctrl_pkg.sv
// Shared types and constants for the board I/O controller: FSM states,
// key roles and the error display nibble.
package board_io_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VIEW    = 3'd1,
    ST_ARM     = 3'd2,
    ST_WAIT_WB = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  localparam int NUM_KEYS_DEF = 4;
  localparam int KEY_VIEW     = 0;
  localparam int KEY_EXEC     = NUM_KEYS_DEF - 1;

  localparam logic [3:0] ERR_NIBBLE = 4'hE;

  // EXEC is always the highest-numbered key, whatever the key count.
  function automatic int key_exec_idx(input int num_keys);
    return num_keys - 1;
  endfunction

endpackage

// File: rtl/board_io_ctrl_key_debounce.sv
// One push key: two-flop synchronizer, stability counter, debounced level
// and a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             armed_q, armed_d;
  logic             raw_s;

  assign raw_s   = sync_q[1];
  assign level_o = level_q;
  assign press_o = press_q;

  // Counter, level and press decision; a key must be seen released
  // (armed) before any fall may produce a press.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    armed_d = armed_q;
    if (raw_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = raw_s;
        cnt_d   = '0;
        press_d = level_q & armed_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      if (level_q) begin
        armed_d = 1'b1;
      end else begin
        armed_d = armed_q;
      end
    end
  end

  // Synchronizer resets to "pressed" so a key held through reset is never
  // taken as released, and thus never arms a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced keys drive a view/execute FSM that issues
// instructions to a core and shows results or register contents on hex digits.
module board_io_ctrl
  import board_io_ctrl_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_KEYS-1:0]     key_n_i,
  input  logic [DATA_W-1:0]       sw_i,
  input  logic                    go_i,
  input  logic                    ready_i,
  input  logic                    wen_i,
  input  logic [DATA_W-1:0]       res_i,
  input  logic [DATA_W-1:0]       reg_a_i,
  input  logic [DATA_W-1:0]       reg_b_i,
  output logic                    start_o,
  output logic                    is_view_o,
  output logic [ADDR_W-1:0]       view_addr_a_o,
  output logic [ADDR_W-1:0]       view_addr_b_o,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int H        = NUM_DIGITS / 2;
  localparam int Q        = NUM_DIGITS / 4;
  localparam int EXEC_IDX = key_exec_idx(NUM_KEYS);
  localparam int TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [NUM_KEYS-1:0] key_lvl_s, key_press_s;
  logic                view_lvl_s, exec_press_s;
  state_e              state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                rv_q, rv_d;
  logic                start_q, is_view_q, busy_q, err_q;
  logic                unused_s;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .key_n_i (key_n_i[g]),
      .level_o (key_lvl_s[g]),
      .press_o (key_press_s[g])
    );
  end

  assign view_lvl_s    = key_lvl_s[KEY_VIEW];
  assign exec_press_s  = key_press_s[EXEC_IDX];
  assign view_addr_a_o = sw_i[8 +: ADDR_W];
  assign view_addr_b_o = sw_i[4 +: ADDR_W];
  assign start_o       = start_q;
  assign is_view_o     = is_view_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign unused_s      = ^{sw_i, reg_a_i, reg_b_i, result_q, key_lvl_s, key_press_s};

  // Next state, timeout and result capture; wen during the start cycle is ignored.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    rv_d     = rv_q;
    case (state_q)
      ST_IDLE: begin
        if (!view_lvl_s) begin
          state_d = ST_VIEW;
        end else if (exec_press_s && go_i) begin
          state_d = ST_ARM;
          tmo_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VIEW: begin
        if (view_lvl_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_VIEW;
        end
      end
      ST_ARM: begin
        if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end else if (ready_i) begin
          state_d = ST_WAIT_WB;
          tmo_d   = tmo_q + TMO_W'(1);
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      ST_WAIT_WB: begin
        if (wen_i && !start_q) begin
          result_d = res_i;
          rv_d     = 1'b1;
          state_d  = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      ST_ERR: begin
        if (exec_press_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and registered status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      start_q   <= 1'b0;
      is_view_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      start_q   <= (state_q == ST_ARM) && (state_d == ST_WAIT_WB);
      is_view_q <= (state_d == ST_VIEW);
      busy_q    <= (state_d == ST_ARM) || (state_d == ST_WAIT_WB);
      err_q     <= (state_d == ST_ERR);
    end
  end

  // Digit contents and blanking: result in the lower half, reg_b/reg_a above.
  always_comb begin
    digits_o = '0;
    blank_o  = '1;
    digits_o[4*H-1:0]       = result_q[4*H-1:0];
    digits_o[4*H +: 4*Q]     = reg_b_i[4*Q-1:0];
    digits_o[4*(H+Q) +: 4*Q] = reg_a_i[4*Q-1:0];
    if (state_q == ST_ERR) begin
      for (int i = 0; i < H; i++) begin
        digits_o[4*i +: 4] = ERR_NIBBLE;
      end
      blank_o[H-1:0] = '0;
    end else begin
      blank_o[H-1:0] = {H{~rv_q | is_view_q}};
    end
    blank_o[NUM_DIGITS-1:H] = {(NUM_DIGITS-H){~is_view_q}};
  end

endmodule

// File: doc/board_io_ctrl.md
BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 Parameter DATA_W, 16, width of switch word, result and register views.
REQ-002 Parameter ADDR_W, 4, register-address width used in view mode.
REQ-003 Parameter NUM_DIGITS, 8, number of 7-segment digits driven; multiple of 4, with 2*NUM_DIGITS <= DATA_W.
REQ-004 Parameter NUM_KEYS, 4, number of push keys; key 0 = VIEW, key NUM_KEYS-1 = EXEC.
REQ-005 Parameter DEBOUNCE_CYC, 50000, stable cycles required before a key level is accepted.
REQ-006 Parameter TIMEOUT_CYC, 1000000, cycles allowed in ARM+WAIT_WB before the error state.
REQ-007 CLK  in  1  single clock; every flop is on its rising edge.
REQ-008 RST  in  1  reset, asynchronous and active-low.
REQ-009 key_n  in  NUM_KEYS  raw active-low board keys.
REQ-010 sw  in  DATA_W  switch word; sw[11:8] gives the view address A and sw[7:4] gives view address B.
REQ-011 go  in  1  execute enable; an EXEC press is accepted only while go=1.
REQ-012 ready  in  1  core ready to accept an instruction.
REQ-013 wen  in  1  core writeback strobe.
REQ-014 res  in  DATA_W  core result.
REQ-015 reg_a, reg_b  in  DATA_W  register-bank read data.
REQ-016 start  out  1  one-cycle instruction-issue pulse.
REQ-017 is_view  out  1  high selects view_addr_a/b as register-bank read addresses.
REQ-018 view_addr_a, view_addr_b  out  ADDR_W  combinational copies of sw[11:8] and sw[7:4].
REQ-019 digits  out  4*NUM_DIGITS  hex nibble per digit; digit 0 in the LSBs.
REQ-020 blank  out  NUM_DIGITS  per-digit blank; 1 = digit off.
REQ-021 busy  out  1  high in ARM or WAIT_WB.
REQ-022 err  out  1  high in ERR.

Function
REQ-023 Debounce: each key has its own counter; the debounced level changes only after raw input differs from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
REQ-024 Press pulse: one cycle, generated on the debounced 1->0 transition of a key.
REQ-025 FSM states: IDLE, VIEW, ARM, WAIT_WB, ERR.
REQ-026 IDLE: debounced VIEW low -> VIEW. EXEC pulse with go=1 -> ARM. EXEC pulse with go=0 is dropped.
REQ-027 IDLE, VIEW and EXEC in the same cycle: VIEW wins and the EXEC pulse is dropped.
REQ-028 VIEW: is_view=1; stays while debounced VIEW is low, then -> IDLE on release; EXEC pulses are ignored.
REQ-029 ARM: waits for ready=1, then -> WAIT_WB; start is registered and high exactly during the first WAIT_WB cycle.
REQ-030 WAIT_WB: wen is sampled from the cycle after start onward. On wen=1: result <= res, result_valid <= 1, -> IDLE. wen seen in ARM is ignored.
REQ-031 Timeout counter: cleared on entry to ARM and increments in ARM/WAIT_WB. Reaching TIMEOUT_CYC-1 without completion -> ERR; wen in that same cycle takes priority and completes normally.
REQ-032 ERR: err=1; an EXEC pulse -> IDLE; VIEW is ignored; result and result_valid are kept.
REQ-033 Display, lower half (H=NUM_DIGITS/2 digits): shows result[4H-1:0]. These digits are blanked when result_valid=0 or is_view=1. In ERR, every nibble is 0xE and unblanked.
REQ-034 Display, upper half: the next Q=NUM_DIGITS/4 digits show reg_b[4Q-1:0] and the top Q digits show reg_a[4Q-1:0]. These digits are unblanked only when is_view=1.

Reset
REQ-035 RST low, at any time including mid-transaction: state=IDLE; start=0, is_view=0, busy=0, err=0; result=0, result_valid=0; counters=0; debounced levels=1 (released); all digits blanked.
REQ-036 Reset release: no press pulse is generated from keys already held; a press needs a fresh debounced transition.

Structure
REQ-037 The shared package holds the FSM state enum, the key index constants KEY_VIEW=0 and KEY_EXEC=NUM_KEYS-1, and the ERR display nibble 0xE.
REQ-038 Sub-module key_debounce (one key: counter, debounced level, press pulse) is instantiated NUM_KEYS times. Seven-segment decoding stays outside this block.

Verification (DEBOUNCE_CYC=4, TIMEOUT_CYC=16, default widths)
REQ-039 EXEC held 2 cycles, then released: no pulse, state stays IDLE. EXEC held 6 cycles: exactly one ARM entry.
REQ-040 go=1, ready=1, EXEC press, wen=1 with res=0x1234 two cycles after start: one start pulse, digits[15:0]=0x1234, blank=8'hF0.
REQ-041 VIEW held, sw[11:8]=3, sw[7:4]=5, reg_a=0x00AB, reg_b=0x00CD: is_view=1, view_addr_a=3, view_addr_b=5, upper nibbles AB CD, blank=8'h0F; VIEW release gives is_view=0.
REQ-042 EXEC press with ready=0 for 16 cycles: err=1, lower digits EEEE; next EXEC press returns to IDLE with err=0.
REQ-043 RST low during WAIT_WB, then a late wen: state IDLE, result_valid=0, no capture, all digits blank.
REQ-044 VIEW and EXEC debounced in the same cycle: VIEW entered, start never asserted.
